xgmii_tx_arbiter: RTL and testbench

//  Round-robin scheduler sharing the single XGMII TX lane set between NREQ frame sources.

---
 rtl/xgmii_tx_arbiter.sv | 153 +++++++++++++++
 tb/tb_xgmii_tx_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xgmii_tx_arbiter.sv
`default_nettype none
// =============================================================================
// Module  : xgmii_tx_arbiter
// Purpose : Round-robin whole-frame scheduler from NREQ FWFT FIFOs onto one XGMII TX port
// Rev     : 1.0  initial release
// =============================================================================
module xgmii_tx_arbiter #(
  parameter int NREQ            = 2,
  parameter int IPG_CYCLES      = 1,
  parameter int MAX_FRAME_WORDS = 200
) (
  input  logic               xgmii_clk,
  input  logic               sys_rst,
  input  logic               tx_en,
  input  logic [NREQ*72-1:0] src_dout,
  input  logic [NREQ-1:0]    src_empty,
  output logic [NREQ-1:0]    src_rd_en,
  output logic [7:0]         xgmii_txc,
  output logic [63:0]        xgmii_txd,
  output logic [NREQ-1:0]    grant,
  output logic [31:0]        frames_sent,
  output logic [15:0]        frames_abort
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WW = $clog2(MAX_FRAME_WORDS + 1);
  localparam int GW = (IPG_CYCLES > 1) ? $clog2(IPG_CYCLES) : 1;
  localparam logic [WW-1:0] C_MAX_WORDS = WW'(MAX_FRAME_WORDS);
  localparam logic [GW-1:0] C_IPG_LAST  = GW'(IPG_CYCLES - 1);
  localparam logic [IW-1:0] C_PTR_RST   = IW'(NREQ - 1);
  localparam logic [63:0]   C_IDLE_D    = 64'h0707_0707_0707_0707;
  localparam logic [63:0]   C_ERR_D     = 64'hFEFE_FEFE_FEFE_FEFE;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SEND  = 2'd1,
    S_ABORT = 2'd2,
    S_IPG   = 2'd3
  } state_t;

  state_t          state;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   gidx;
  logic [WW-1:0]   wcnt;
  logic [GW-1:0]   ipg_cnt;

  logic [71:0]     head [NREQ];
  logic [IW-1:0]   cand;
  logic [IW-1:0]   win_idx;
  logic            win_found;
  logic [IW-1:0]   sel;
  logic [71:0]     word;
  logic            is_start;
  logic            is_term;
  logic            pop;

  for (genvar g = 0; g < NREQ; g++) begin : g_head
    assign head[g] = src_dout[72*g +: 72];
  end

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    // Scan starts one past the last owner so every source gets its turn.
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(rr_ptr) + k) % NREQ);
      if (!win_found && !src_empty[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
    sel      = (state == S_IDLE) ? win_idx : gidx;
    word     = head[sel];
    is_start = (word[71:64] == 8'h01) && (word[7:0] == 8'hFB);
    is_term  = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (word[64+k] && (word[8*k +: 8] == 8'hFD)) is_term = 1'b1;
    end
    case (state)
      S_IDLE:  pop = tx_en && win_found;
      S_SEND:  pop = !src_empty[gidx] && (wcnt < C_MAX_WORDS);
      S_ABORT: pop = !src_empty[gidx];
      default: pop = 1'b0;
    endcase
    if (sys_rst) pop = 1'b0;
    src_rd_en = pop ? (NREQ'(1) << sel) : '0;
  end

  always_ff @(posedge xgmii_clk) begin
    if (sys_rst) begin
      state        <= S_IDLE;
      xgmii_txc    <= 8'hFF;
      xgmii_txd    <= C_IDLE_D;
      grant        <= '0;
      rr_ptr       <= C_PTR_RST;
      gidx         <= '0;
      wcnt         <= '0;
      ipg_cnt      <= '0;
      frames_sent  <= '0;
      frames_abort <= '0;
    end else begin
      xgmii_txc <= 8'hFF;
      xgmii_txd <= C_IDLE_D;
      case (state)
        S_IDLE: begin
          if (pop) begin
            if (is_start) begin
              xgmii_txc <= word[71:64];
              xgmii_txd <= word[63:0];
              grant     <= NREQ'(1) << win_idx;
              rr_ptr    <= win_idx;
              gidx      <= win_idx;
              wcnt      <= WW'(1);
              state     <= S_SEND;
            end else if (frames_abort != 16'hFFFF) begin
              frames_abort <= frames_abort + 16'd1;
            end
          end
        end
        S_SEND: begin
          if (pop) begin
            xgmii_txc <= word[71:64];
            xgmii_txd <= word[63:0];
            wcnt      <= wcnt + WW'(1);
            if (is_term) begin
              frames_sent <= frames_sent + 32'd1;
              ipg_cnt     <= '0;
              state       <= S_IPG;
            end
          end else begin
            // Underflow or watchdog: poison the frame so the PHY peer drops it.
            xgmii_txc <= 8'hFF;
            xgmii_txd <= C_ERR_D;
            if (frames_abort != 16'hFFFF) frames_abort <= frames_abort + 16'd1;
            state <= S_ABORT;
          end
        end
        S_ABORT: begin
          if (pop && is_term) begin
            ipg_cnt <= '0;
            state   <= S_IPG;
          end
        end
        default: begin
          grant <= '0;
          if (ipg_cnt == C_IPG_LAST) state <= S_IDLE;
          else ipg_cnt <= ipg_cnt + GW'(1);
        end
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_xgmii_tx_arbiter.sv
`default_nettype none
// Bench for xgmii_tx_arbiter: directed steps plus randomized frame mixes,
// checked against a frame-level round-robin model.
module tb_xgmii_tx_arbiter;
  localparam int NREQ = 2;
  localparam int IPG  = 1;
  localparam int MAXW = 4;
  localparam logic [71:0] IDLEW = {8'hFF, 64'h0707_0707_0707_0707};
  localparam logic [71:0] ERRW  = {8'hFF, 64'hFEFE_FEFE_FEFE_FEFE};

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               tx_en = 1'b0;
  logic [NREQ*72-1:0] src_dout;
  logic [NREQ-1:0]    src_empty;
  logic [NREQ-1:0]    src_rd_en;
  logic [7:0]         txc;
  logic [63:0]        txd;
  logic [NREQ-1:0]    grant;
  logic [31:0]        frames_sent;
  logic [15:0]        frames_abort;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [71:0] fq [NREQ][$];
  logic [71:0] mq [NREQ][$];
  logic [71:0] obsq [$];
  logic [71:0] expq [$];
  logic [NREQ-1:0] pend = '0;
  logic [71:0] mon_w;
  logic        prev_end = 1'b0;
  int          mptr = NREQ - 1;
  logic [31:0] exp_sent = '0;
  int          exp_abort = 0;
  int          fid = 0;
  int          found;
  logic [71:0] uw0, uw1;

  xgmii_tx_arbiter #(.NREQ(NREQ), .IPG_CYCLES(IPG), .MAX_FRAME_WORDS(MAXW)) dut (
    .xgmii_clk(clk), .sys_rst(rst), .tx_en(tx_en), .src_dout(src_dout),
    .src_empty(src_empty), .src_rd_en(src_rd_en), .xgmii_txc(txc), .xgmii_txd(txd),
    .grant(grant), .frames_sent(frames_sent), .frames_abort(frames_abort)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_start(input logic [71:0] w);
    return (w[71:64] == 8'h01) && (w[7:0] == 8'hFB);
  endfunction

  function automatic bit is_term(input logic [71:0] w);
    bit t = 1'b0;
    for (int k = 0; k < 8; k++) if (w[64+k] && w[8*k +: 8] == 8'hFD) t = 1'b1;
    return t;
  endfunction

  function automatic logic [71:0] mk_start(input int s, input int f);
    return {8'h01, 8'(s), 8'(f), 8'hA5, 8'h55, 8'h55, 8'h55, 8'hD5, 8'hFB};
  endfunction

  function automatic logic [71:0] mk_data(input int s, input int f, input int i);
    return {8'h00, 8'(s), 8'(f), 8'(i), 8'h00, $urandom()};
  endfunction

  function automatic logic [71:0] mk_term(input int lane);
    logic [7:0]  c;
    logic [63:0] d;
    int k;
    k = (lane < 0) ? int'($urandom_range(7, 0)) : lane;
    for (int j = 0; j < 8; j++) begin
      if (j < k)       begin c[j] = 1'b0; d[8*j +: 8] = 8'($urandom_range(255, 0)); end
      else if (j == k) begin c[j] = 1'b1; d[8*j +: 8] = 8'hFD; end
      else             begin c[j] = 1'b1; d[8*j +: 8] = 8'h07; end
    end
    return {c, d};
  endfunction

  function automatic void drive();
    for (int s = 0; s < NREQ; s++) begin
      src_dout[72*s +: 72] = (fq[s].size() > 0) ? fq[s][0] : 72'd0;
      src_empty[s]         = (fq[s].size() == 0);
    end
  endfunction

  task automatic put(input int s, input logic [71:0] w, input bit to_model);
    fq[s].push_back(w);
    if (to_model) mq[s].push_back(w);
  endtask

  task automatic put_frame(input int s, input int len, input int lane, input bit to_model);
    fid++;
    put(s, mk_start(s, fid), to_model);
    for (int i = 1; i <= len - 2; i++) put(s, mk_data(s, fid, i), to_model);
    put(s, mk_term(lane), to_model);
  endtask

  task automatic bump_abort();
    if (exp_abort < 65535) exp_abort++;
  endtask

  // Frame-level reference: round robin over queued items, junk heads discarded,
  // frames truncated to MAXW words followed by one error word.
  task automatic run_model();
    int s, n;
    logic [71:0] w;
    bit done, errd;
    while (mq[0].size() + mq[1].size() > 0) begin
      s = -1;
      for (int k = 1; k <= NREQ; k++)
        if (s < 0 && mq[(mptr + k) % NREQ].size() > 0) s = (mptr + k) % NREQ;
      w = mq[s].pop_front();
      if (!is_start(w)) begin
        bump_abort();
      end else begin
        mptr = s; expq.push_back(w); n = 1; done = 1'b0; errd = 1'b0;
        while (!done && mq[s].size() > 0) begin
          w = mq[s].pop_front();
          if (n < MAXW) begin
            expq.push_back(w); n++;
            if (is_term(w)) begin done = 1'b1; exp_sent++; end
          end else begin
            if (!errd) begin expq.push_back(ERRW); bump_abort(); errd = 1'b1; end
            if (is_term(w)) done = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drain_check(input string tag);
    int quiet = 0;
    int cyc = 0;
    while (quiet < 3 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (fq[0].size() == 0 && fq[1].size() == 0 && grant == '0 && {txc, txd} === IDLEW) quiet++;
      else quiet = 0;
    end
    chk({tag, "_drained"}, 72'(quiet >= 3), 72'd1);
    chk({tag, "_nwords"}, 72'(obsq.size()), 72'(expq.size()));
    for (int i = 0; i < obsq.size() && i < expq.size(); i++) chk({tag, "_word"}, obsq[i], expq[i]);
    chk({tag, "_sent"}, 72'(frames_sent), 72'(exp_sent));
    chk({tag, "_abort"}, 72'(frames_abort), 72'(exp_abort));
    obsq.delete();
    expq.delete();
  endtask

  // FWFT FIFO model: pops follow the pop request seen mid-cycle.
  always @(posedge clk) begin
    #1;
    for (int s = 0; s < NREQ; s++) if (pend[s] && fq[s].size() > 0) void'(fq[s].pop_front());
    drive();
  end

  always @(negedge clk) begin
    mon_w = {txc, txd};
    pend  = src_rd_en;
    chk("rd_en_onehot0", 72'($onehot0(src_rd_en)), 72'd1);
    chk("rd_en_when_empty", 72'(src_rd_en & src_empty), 72'd0);
    if (prev_end) chk("gap_after_frame", mon_w, IDLEW);
    if (mon_w !== IDLEW) begin
      obsq.push_back(mon_w);
      chk("grant_while_tx", 72'(grant != '0), 72'd1);
    end
    prev_end = (mon_w !== IDLEW) && (is_term(mon_w) || mon_w === ERRW);
  end

  initial begin
    drive();
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_txc_txd", {txc, txd}, IDLEW);
    chk("rst_grant", 72'(grant), 72'd0);
    chk("rst_rd_en", 72'(src_rd_en), 72'd0);
    chk("rst_sent", 72'(frames_sent), 72'd0);
    chk("rst_abort", 72'(frames_abort), 72'd0);
    tick();
    rst = 1'b0;

    // tx_en low: loaded FIFO must not be touched
    put_frame(0, 3, 3, 1'b1);
    drive();
    run_model();
    repeat (4) begin
      @(negedge clk);
      chk("txen0_no_pop", 72'(src_rd_en), 72'd0);
      chk("txen0_idle", {txc, txd}, IDLEW);
    end

    // Single 3-word frame, exact cycle timing
    tick();
    tx_en = 1'b1;
    @(negedge clk);
    chk("t1_arb_pop", 72'(src_rd_en), 72'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t1_word", {txc, txd}, expq[i]);
      chk("t1_grant", 72'(grant), 72'd1);
    end
    @(negedge clk);
    chk("t1_ipg_idle", {txc, txd}, IDLEW);
    chk("t1_grant_clear", 72'(grant), 72'd0);
    chk("t1_sent", 72'(frames_sent), 72'd1);
    drain_check("t1");

    // Two frames per source queued at once
    tick();
    put_frame(0, 3, -1, 1'b1);
    put_frame(1, 4, -1, 1'b1);
    put_frame(0, 4, -1, 1'b1);
    put_frame(1, 3, -1, 1'b1);
    drive();
    run_model();
    drain_check("rr2x2");

    // Junk head ahead of a valid frame
    tick();
    put(0, {8'h00, $urandom(), $urandom()}, 1'b1);
    put_frame(0, 3, -1, 1'b1);
    drive();
    run_model();
    drain_check("junk");

    // Runaway 10-word frame hits the watchdog
    tick();
    put_frame(0, 10, -1, 1'b1);
    drive();
    run_model();
    drain_check("watchdog");

    // Source 1 underflows after two words; rest arrives later and is drained
    tick();
    fid++;
    uw0 = mk_start(1, fid);
    uw1 = mk_data(1, fid, 1);
    put(1, uw0, 1'b0);
    put(1, uw1, 1'b0);
    drive();
    expq.push_back(uw0);
    expq.push_back(uw1);
    expq.push_back(ERRW);
    bump_abort();
    mptr = 1;
    repeat (8) @(negedge clk);
    chk("uf_abort_now", 72'(frames_abort), 72'(exp_abort));
    chk("uf_grant_held", 72'(grant), 72'd2);
    chk("uf_out_idle", {txc, txd}, IDLEW);
    tick();
    put(1, mk_data(1, fid, 2), 1'b0);
    put(1, mk_term(-1), 1'b0);
    put_frame(0, 3, -1, 1'b1);
    drive();
    run_model();
    drain_check("underflow");

    // Randomized mixes of frames and junk on both sources
    for (int r = 0; r < 8; r++) begin
      tick();
      for (int s = 0; s < NREQ; s++) begin
        for (int j = 0; j < int'($urandom_range(3, 1)); j++) begin
          if ($urandom_range(4, 0) == 0) put(s, {8'h00, $urandom(), $urandom()}, 1'b1);
          else put_frame(s, int'($urandom_range(6, 2)), -1, 1'b1);
        end
      end
      drive();
      run_model();
      drain_check("random");
    end

    // Reset in the middle of a frame
    tick();
    put_frame(0, 4, -1, 1'b0);
    drive();
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      @(negedge clk);
      if (txc == 8'h01 && txd[7:0] == 8'hFB) found = 1;
    end
    chk("mr_start_seen", 72'(found), 72'd1);
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("mr_no_pop_in_rst", 72'(src_rd_en), 72'd0);
    @(negedge clk);
    chk("mr_out_idle", {txc, txd}, IDLEW);
    chk("mr_grant", 72'(grant), 72'd0);
    chk("mr_sent", 72'(frames_sent), 72'd0);
    chk("mr_abort", 72'(frames_abort), 72'd0);
    chk("mr_leftover", 72'(fq[0].size()), 72'd2);
    tick();
    rst = 1'b0;
    obsq.delete();
    expq.delete();
    exp_sent  = '0;
    exp_abort = 2;
    mptr      = NREQ - 1;
    put_frame(0, 3, -1, 1'b1);
    drive();
    run_model();
    drain_check("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
